// File: rtl/cpu_pkg.sv
// Shared op-code definitions for the operand stack and the CPU decoder.
package cpu_pkg;

  typedef enum logic [2:0] {
    OpNop  = 3'b000,
    OpPush = 3'b001,
    OpPop  = 3'b010,
    OpRepl = 3'b011,
    OpBin  = 3'b100,
    OpDup  = 3'b101,
    OpSwap = 3'b110,
    OpOver = 3'b111
  } op_e;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_REPL = 3'b011;
  localparam logic [2:0] OP_BIN  = 3'b100;
  localparam logic [2:0] OP_DUP  = 3'b101;
  localparam logic [2:0] OP_SWAP = 3'b110;
  localparam logic [2:0] OP_OVER = 3'b111;

endpackage

// File: rtl/stack_mem.sv
// Storage for stack entries below the top two; one write port, one async read port.
module stack_mem #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MemDepth = 14,
  parameter int unsigned AddrW    = 4
) (
  input  logic             i_clock,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AddrW-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [MemDepth];

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // Addresses past the array only occur when the caller ignores the data.
  always_comb begin
    o_rdata = '0;
    if (int'(i_raddr) < int'(MemDepth)) begin
      o_rdata = mem_q[i_raddr];
    end
  end

endmodule

// File: rtl/param_stack.sv
// Operand stack: top/next in registers, deeper entries in stack_mem.
module param_stack
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic [2:0]                 i_op,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_clr_err,
  output logic [WIDTH-1:0]           o_top,
  output logic [WIDTH-1:0]           o_next,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_error
);

  localparam int unsigned CntW     = $clog2(DEPTH + 1);
  localparam int unsigned MemDepth = (DEPTH > 2) ? DEPTH - 2 : 1;
  localparam int unsigned AddrW    = (MemDepth > 1) ? $clog2(MemDepth) : 1;

  logic [WIDTH-1:0] top_q, top_d, next_q, next_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             err_q, err_d;

  logic             legal;
  logic             mem_we;
  logic [CntW-1:0]  wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rd_data, third;
  op_e              op;

  assign wr_ptr = count_q - CntW'(2);
  assign rd_ptr = count_q - CntW'(3);
  assign third  = (count_q >= CntW'(3)) ? rd_data : '0;

  always_comb begin
    op      = op_e'(i_op);
    legal   = 1'b1;
    top_d   = top_q;
    next_d  = next_q;
    count_d = count_q;
    mem_we  = 1'b0;
    unique case (op)
      OpNop:  legal = 1'b1;
      OpPush: legal = (count_q < CntW'(DEPTH));
      OpPop:  legal = (count_q >= CntW'(1));
      OpRepl: legal = (count_q >= CntW'(1));
      OpBin:  legal = (count_q >= CntW'(2));
      OpDup:  legal = (count_q >= CntW'(1)) && (count_q < CntW'(DEPTH));
      OpSwap: legal = (count_q >= CntW'(2));
      OpOver: legal = (count_q >= CntW'(2)) && (count_q < CntW'(DEPTH));
    endcase
    if (legal) begin
      unique case (op)
        OpNop: ;
        OpPush: begin
          top_d   = i_data;
          next_d  = top_q;
          count_d = count_q + CntW'(1);
          mem_we  = (count_q >= CntW'(2));
        end
        OpPop: begin
          top_d   = next_q;
          next_d  = third;
          count_d = count_q - CntW'(1);
        end
        OpRepl: top_d = i_data;
        OpBin: begin
          top_d   = i_data;
          next_d  = third;
          count_d = count_q - CntW'(1);
        end
        OpDup: begin
          next_d  = top_q;
          count_d = count_q + CntW'(1);
          mem_we  = (count_q >= CntW'(2));
        end
        OpSwap: begin
          top_d  = next_q;
          next_d = top_q;
        end
        OpOver: begin
          top_d   = next_q;
          next_d  = top_q;
          count_d = count_q + CntW'(1);
          mem_we  = (count_q >= CntW'(2));
        end
      endcase
    end
    // A violation on the same edge as a clear wins.
    err_d = (err_q & ~i_clr_err) | ~legal;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      top_q   <= '0;
      next_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      next_q  <= next_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  stack_mem #(
    .WIDTH   (WIDTH),
    .MemDepth(MemDepth),
    .AddrW   (AddrW)
  ) u_stack_mem (
    .i_clock(i_clock),
    .i_we   (mem_we & i_reset_n),
    .i_waddr(wr_ptr[AddrW-1:0]),
    .i_wdata(next_q),
    .i_raddr(rd_ptr[AddrW-1:0]),
    .o_rdata(rd_data)
  );

  assign o_top   = top_q;
  assign o_next  = next_q;
  assign o_count = count_q;
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CntW'(DEPTH));
  assign o_error = err_q;

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack against a queue-based stack model.
module tb_param_stack;

  localparam int unsigned Width = 16;
  localparam int unsigned Depth = 4;
  localparam int unsigned CntW  = $clog2(Depth + 1);

  localparam logic [2:0] Nop = 3'd0, Push = 3'd1, Pop = 3'd2, Repl = 3'd3;
  localparam logic [2:0] Bin = 3'd4, Dup = 3'd5, Swap = 3'd6, Over = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       op;
  logic [Width-1:0] data;
  logic             clr;
  logic [Width-1:0] top, nxt;
  logic [CntW-1:0]  count;
  logic             empty, full, error;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [Width-1:0] model_q [$];
  logic             model_err = 1'b0;

  always #5 clk = ~clk;

  param_stack #(
    .WIDTH(Width),
    .DEPTH(Depth)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .i_op     (op),
    .i_data   (data),
    .i_clr_err(clr),
    .o_top    (top),
    .o_next   (nxt),
    .o_count  (count),
    .o_empty  (empty),
    .o_full   (full),
    .o_error  (error)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic [2:0] o, input logic [Width-1:0] d, input logic c,
                            input logic r);
    int  n;
    bit  ok;
    logic [Width-1:0] t;
    if (!r) begin
      model_q.delete();
      model_err = 1'b0;
      return;
    end
    n = model_q.size();
    case (o)
      Push:       ok = n < Depth;
      Pop, Repl:  ok = n >= 1;
      Bin, Swap:  ok = n >= 2;
      Dup:        ok = n >= 1 && n < Depth;
      Over:       ok = n >= 2 && n < Depth;
      default:    ok = 1'b1;
    endcase
    if (ok) begin
      case (o)
        Push: model_q.push_back(d);
        Pop:  void'(model_q.pop_back());
        Repl: model_q[n-1] = d;
        Bin: begin
          void'(model_q.pop_back());
          void'(model_q.pop_back());
          model_q.push_back(d);
        end
        Dup:  model_q.push_back(model_q[n-1]);
        Swap: begin
          t = model_q[n-1];
          model_q[n-1] = model_q[n-2];
          model_q[n-2] = t;
        end
        Over: model_q.push_back(model_q[n-2]);
        default: ;
      endcase
    end
    model_err = (model_err & ~c) | ~ok;
  endtask

  task automatic compare_all();
    int n = model_q.size();
    check_eq("top",   top,   (n > 0) ? model_q[n-1] : '0);
    check_eq("next",  nxt,   (n > 1) ? model_q[n-2] : '0);
    check_eq("count", count, n);
    check_eq("empty", empty, n == 0);
    check_eq("full",  full,  n == Depth);
    check_eq("error", error, model_err);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [Width-1:0] d, input logic c = 1'b0,
                       input logic r = 1'b1);
    @(negedge clk);
    op = o; data = d; clr = c; rst_n = r;
    @(posedge clk);
    #1;
    model_step(o, d, c, r);
    compare_all();
  endtask

  task automatic do_reset();
    do_op(Nop, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; op = Nop; data = '0; clr = 1'b0;
    do_reset();
    check_eq("rst_empty", empty, 1);

    // Fill, overflow, clear error
    do_op(Push, 16'h1111); do_op(Push, 16'h2222);
    do_op(Push, 16'h3333); do_op(Push, 16'h4444);
    check_eq("fill_top", top, 16'h4444);
    check_eq("fill_next", nxt, 16'h3333);
    check_eq("fill_full", full, 1);
    do_op(Push, 16'h5555);
    check_eq("ovf_err", error, 1);
    check_eq("ovf_top", top, 16'h4444);
    do_op(Nop, '0, 1'b1);
    check_eq("clr_err", error, 0);
    // Drain checks deeper entries survive
    do_op(Pop, '0); do_op(Pop, '0); do_op(Pop, '0);
    check_eq("drain_top", top, 16'h1111);
    do_op(Pop, '0);

    // BIN
    do_reset();
    do_op(Push, 16'h1111); do_op(Push, 16'h0005); do_op(Push, 16'h0003);
    do_op(Bin, 16'h0008);
    check_eq("bin_top", top, 16'h0008);
    check_eq("bin_next", nxt, 16'h1111);
    check_eq("bin_count", count, 2);

    // SWAP / OVER / DUP
    do_reset();
    do_op(Push, 16'h00AA); do_op(Push, 16'h00BB);
    do_op(Swap, '0);
    check_eq("swap_top", top, 16'h00AA);
    check_eq("swap_next", nxt, 16'h00BB);
    do_op(Over, '0);
    check_eq("over_top", top, 16'h00BB);
    check_eq("over_count", count, 3);
    do_op(Dup, '0);
    check_eq("dup_count", count, 4);
    check_eq("dup_top", top, 16'h00BB);

    // Underflow cases; violation coinciding with clear keeps error set
    do_reset();
    do_op(Pop, '0);
    check_eq("unf_err", error, 1);
    do_op(Pop, '0, 1'b1);
    check_eq("clr_vs_viol", error, 1);
    do_reset();
    do_op(Push, 16'h0007);
    do_op(Bin, 16'h0009);
    check_eq("bin1_err", error, 1);
    check_eq("bin1_top", top, 16'h0007);

    // Reset concurrent with PUSH
    do_reset();
    do_op(Push, 16'h0001); do_op(Push, 16'h0002); do_op(Push, 16'h0003);
    do_op(Push, 16'h0004, 1'b0, 1'b0);
    check_eq("rst_count", count, 0);
    check_eq("rst_top", top, 0);
    do_op(Pop, '0);

    // Randomized ops against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      do_op(3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 7) == 0,
            $urandom_range(0, 99) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data word width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning maximum number of stored entries (DEPTH >= 2).
REQ-003 The block SHALL have port i_clock  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_reset_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port i_op  input  3  stack operation code, sampled every rising edge.
REQ-006 The block SHALL have port i_data  input  WIDTH  operand for PUSH, REPL and BIN.
REQ-007 The block SHALL have port i_clr_err  input  1  clears the sticky error flag.
REQ-008 The block SHALL have port o_top  output  WIDTH  top-of-stack word, registered.
REQ-009 The block SHALL have port o_next  output  WIDTH  second-from-top word, registered.
REQ-010 The block SHALL have port o_count  output  $clog2(DEPTH+1)  current entry count.
REQ-011 The block SHALL have ports o_empty, o_full  output  1 each  count==0 and count==DEPTH.
REQ-012 The block SHALL have port o_error  output  1  sticky overflow/underflow flag.

Function
REQ-013 Op encodings SHALL be: 000 NOP, 001 PUSH, 010 POP, 011 REPL, 100 BIN, 101 DUP, 110 SWAP, 111 OVER.
REQ-014 Every legal op SHALL take effect at the sampling edge; o_top/o_next/o_count/flags reflect the new state immediately after that edge (one-cycle latency, back-to-back ops every cycle).
REQ-015 PUSH (count<DEPTH): new top = i_data, old top becomes next, count+1.
REQ-016 POP (count>=1): top removed, next becomes top, third entry (or 0) becomes next, count-1.
REQ-017 REPL (count>=1): top = i_data, count unchanged.
REQ-018 BIN (count>=2): top and next both removed, i_data pushed as new top, count-1 (ALU result replaces two operands).
REQ-019 DUP (count>=1, count<DEPTH): copy of top pushed, count+1.
REQ-020 SWAP (count>=2): top and next exchanged, count unchanged.
REQ-021 OVER (count>=2, count<DEPTH): copy of next pushed, count+1.
REQ-022 An op violating its count precondition SHALL leave all stack state unchanged and set o_error on that edge.
REQ-023 o_error SHALL remain set until reset or an edge with i_clr_err=1; if i_clr_err and a new violation coincide, o_error SHALL be 1.
REQ-024 o_top SHALL read 0 when count==0; o_next SHALL read 0 when count<2.
REQ-025 Entries below next SHALL be preserved exactly across any sequence of legal ops; no wrap-around of the pointer is permitted.

Reset
REQ-026 On a rising edge with i_reset_n=0: count=0, o_top=0, o_next=0, o_error=0, o_empty=1, o_full=0; i_op ignored.
REQ-027 Reset asserted mid-sequence SHALL discard all entries; the first op after release sees an empty stack.
REQ-028 Storage array contents beneath the pointer need not be cleared by reset.

Structure
REQ-029 Op-code localparams SHALL live in a shared package (cpu_pkg) also used by the CPU decoder.
REQ-030 Top and next SHALL be held in dedicated registers; deeper entries in a sub-module stack_mem (DEPTH-2 words, one write port, one read port at pointer).

Verification (WIDTH=16, DEPTH=4)
REQ-031 Reset, PUSH 0x1111, 0x2222, 0x3333, 0x4444 -> o_top=0x4444, o_next=0x3333, count=4, o_full=1, o_error=0.
REQ-032 From full, PUSH 0x5555 -> state unchanged, o_error=1; i_clr_err pulse -> o_error=0.
REQ-033 Stack [0x1111,0x0005,0x0003] top last, BIN i_data=0x0008 -> o_top=0x0008, o_next=0x1111, count=2.
REQ-034 Stack [0x00AA,0x00BB], SWAP -> top=0x00AA, next=0x00BB; OVER -> top=0x00BB, count=3; DUP -> count=4 top=0x00BB.
REQ-035 Empty, POP -> o_error=1, count=0, o_top=0; one-entry, BIN -> o_error=1, top unchanged.
REQ-036 Count=3, i_reset_n=0 for one edge concurrently with PUSH -> count=0, o_top=0, o_empty=1.
